// File: rtl/uart_share_arbiter.sv
// uart_share_arbiter
// Shares one simpleuart data port between NREQ byte-stream requesters.
// TX side: round-robin arbitration with a packet lock held until a byte
// tagged last is written (or an optional idle timeout expires).
// RX side: a single holding register captures each received byte and
// presents it to whichever requester owned the UART at capture time.
module uart_share_arbiter #(
  parameter int NREQ         = 2,
  parameter int LOCK_TIMEOUT = 0,
  parameter int IDW          = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req_tx_valid,
  input  logic [8*NREQ-1:0]   req_tx_data,
  input  logic [NREQ-1:0]     req_tx_last,
  output logic [NREQ-1:0]     req_tx_ready,
  output logic [NREQ-1:0]     req_rx_valid,
  output logic [7:0]          req_rx_data,
  input  logic [NREQ-1:0]     req_rx_ready,
  output logic [IDW-1:0]      owner,
  output logic                owner_valid,
  output logic                uart_dat_we,
  output logic [31:0]         uart_dat_di,
  input  logic                uart_dat_wait,
  output logic                uart_dat_re,
  input  logic [31:0]         uart_dat_do
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  // Idle-count value at which the lock is dropped (unused when timeout is 0).
  localparam logic [15:0] TIMEOUT_M1 = 16'(LOCK_TIMEOUT - 1);

  state_t         state_reg;
  logic [IDW-1:0] owner_reg;
  logic [IDW-1:0] last_owner_reg;
  logic           owner_valid_reg;
  logic [15:0]    idle_cnt_reg;
  logic           hold_valid_reg;
  logic [7:0]     hold_data_reg;
  logic [IDW-1:0] hold_dest_reg;

  logic [7:0]     tx_byte [NREQ];
  logic           locked;
  logic           own_valid;
  logic           own_last;
  logic [7:0]     own_data;
  logic           xfer;
  logic           timeout_hit;
  logic           capture;
  logic           pop;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  logic           unused_do_bits;

  // Per-requester byte lanes and per-requester handshake / RX routing.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign tx_byte[gi]      = req_tx_data[8*gi +: 8];
    assign req_tx_ready[gi] = locked && (owner_reg == IDW'(gi)) && !uart_dat_wait;
    assign req_rx_valid[gi] = hold_valid_reg && (hold_dest_reg == IDW'(gi));
  end

  assign locked      = (state_reg == LOCKED);
  assign own_valid   = req_tx_valid[owner_reg];
  assign own_last    = req_tx_last[owner_reg];
  assign own_data    = tx_byte[owner_reg];
  assign xfer        = locked && own_valid && !uart_dat_wait;
  assign timeout_hit = (LOCK_TIMEOUT != 0) && !own_valid && (idle_cnt_reg == TIMEOUT_M1);

  assign uart_dat_we = locked && own_valid;
  assign uart_dat_di = locked ? {24'b0, own_data} : 32'b0;

  // A pending pop keeps the holding register full this cycle, so capture waits one cycle.
  assign capture     = uart_dat_do[8] && !hold_valid_reg;
  assign pop         = hold_valid_reg && req_rx_ready[hold_dest_reg];
  assign uart_dat_re = capture;
  assign req_rx_data = hold_data_reg;

  assign owner       = owner_reg;
  assign owner_valid = owner_valid_reg;

  assign unused_do_bits = ^uart_dat_do[31:9];

  // Round-robin winner: first valid requester after the previous owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last_owner_reg;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
      if (!win_found && req_tx_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // TX lock FSM: grant, hold until last byte or idle timeout, then release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      last_owner_reg  <= IDW'(NREQ - 1);
      owner_valid_reg <= 1'b0;
      idle_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          idle_cnt_reg <= '0;
          if (win_found) begin
            owner_reg       <= win_idx;
            state_reg       <= LOCKED;
            owner_valid_reg <= 1'b1;
          end
        end
        LOCKED: begin
          if (xfer || own_valid) begin
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg != 16'hFFFF) begin
            idle_cnt_reg <= idle_cnt_reg + 16'd1;
          end
          if ((xfer && own_last) || timeout_hit) begin
            state_reg       <= IDLE;
            owner_valid_reg <= 1'b0;
            last_owner_reg  <= owner_reg;
          end
        end
        default: begin
          state_reg       <= IDLE;
          owner_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // RX holding register: capture from the UART, release on the destination's pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
      hold_dest_reg  <= '0;
    end else if (pop) begin
      hold_valid_reg <= 1'b0;
    end else if (capture) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= uart_dat_do[7:0];
      hold_dest_reg  <= owner_reg;
    end
  end

endmodule

// File: tb/tb_uart_share_arbiter.sv
// Directed bench for uart_share_arbiter: instance A (NREQ=2, no timeout)
// and instance B (NREQ=3, LOCK_TIMEOUT=8), with a simple UART write monitor.
module tb_uart_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;

  // Instance A signals
  logic [1:0]  tx_valid_a, tx_last_a, tx_ready_a, rx_valid_a, rx_ready_a;
  logic [15:0] tx_data_a;
  logic [7:0]  rx_data_a;
  logic        owner_a, owner_valid_a, we_a, wait_a, re_a;
  logic [31:0] di_a, do_a;

  // Instance B signals
  logic [2:0]  tx_valid_b, tx_last_b, tx_ready_b, rx_valid_b, rx_ready_b;
  logic [23:0] tx_data_b;
  logic [7:0]  rx_data_b;
  logic [1:0]  owner_b;
  logic        owner_valid_b, we_b, wait_b, re_b;
  logic [31:0] di_b, do_b;

  logic [7:0] log_a[$];
  logic [7:0] log_b[$];

  uart_share_arbiter #(.NREQ(2), .LOCK_TIMEOUT(0)) dut_a (
    .clk(clk), .resetn(resetn),
    .req_tx_valid(tx_valid_a), .req_tx_data(tx_data_a), .req_tx_last(tx_last_a),
    .req_tx_ready(tx_ready_a), .req_rx_valid(rx_valid_a), .req_rx_data(rx_data_a),
    .req_rx_ready(rx_ready_a), .owner(owner_a), .owner_valid(owner_valid_a),
    .uart_dat_we(we_a), .uart_dat_di(di_a), .uart_dat_wait(wait_a),
    .uart_dat_re(re_a), .uart_dat_do(do_a)
  );

  uart_share_arbiter #(.NREQ(3), .LOCK_TIMEOUT(8)) dut_b (
    .clk(clk), .resetn(resetn),
    .req_tx_valid(tx_valid_b), .req_tx_data(tx_data_b), .req_tx_last(tx_last_b),
    .req_tx_ready(tx_ready_b), .req_rx_valid(rx_valid_b), .req_rx_data(rx_data_b),
    .req_rx_ready(rx_ready_b), .owner(owner_b), .owner_valid(owner_valid_b),
    .uart_dat_we(we_b), .uart_dat_di(di_b), .uart_dat_wait(wait_b),
    .uart_dat_re(re_b), .uart_dat_do(do_b)
  );

  // UART-side monitors: record every accepted byte, one line per transaction.
  always @(posedge clk) begin
    if (we_a && !wait_a) begin
      log_a.push_back(di_a[7:0]);
      $display("[%0t] A uart write %02h (owner %0d)", $time, di_a[7:0], owner_a);
    end
    if (we_b && !wait_b) begin
      log_b.push_back(di_b[7:0]);
      $display("[%0t] B uart write %02h (owner %0d)", $time, di_b[7:0], owner_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tx_valid_a = '0; tx_last_a = '0; tx_data_a = '0; rx_ready_a = '0; wait_a = 1'b0; do_a = '0;
    tx_valid_b = '0; tx_last_b = '0; tx_data_b = '0; rx_ready_b = '0; wait_b = 1'b0; do_b = '0;
    tick(); tick();
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({tx_ready_a, rx_valid_a, rx_data_a, owner_a, owner_valid_a, we_a, di_a, re_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: got %h want 0", {tx_ready_a, rx_valid_a, rx_data_a, owner_a, owner_valid_a, we_a, di_a, re_a});
    end
    vectors++;
    if ({tx_ready_b, rx_valid_b, rx_data_b, owner_b, owner_valid_b, we_b, di_b, re_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: got %h want 0", {tx_ready_b, rx_valid_b, rx_data_b, owner_b, owner_valid_b, we_b, di_b, re_b});
    end
    tick();
  endtask

  // req0 sends 41,42,43(last) while req1 waits with 55: no interleaving.
  task automatic test_packet_lock();
    logic [7:0] bytes0 [3] = '{8'h41, 8'h42, 8'h43};
    logic [7:0] expv [4] = '{8'h41, 8'h42, 8'h43, 8'h55};
    logic [7:0] got;
    int idx, budget, base;
    logic acc;
    base = log_a.size();
    tx_data_a = {8'h55, 8'h41}; tx_last_a = 2'b10; tx_valid_a = 2'b11;
    @(negedge clk);
    vectors++;
    if ({owner_valid_a, tx_ready_a} !== 3'b000) begin
      miscompares++; $display("FAIL t1_idle_cycle: got %b want 000", {owner_valid_a, tx_ready_a});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({owner_valid_a, owner_a, tx_ready_a} !== 4'b1001) begin
      miscompares++; $display("FAIL t1_grant0: got %b want 1001", {owner_valid_a, owner_a, tx_ready_a});
    end
    idx = 0; budget = 0;
    while (idx < 3 && budget < 40) begin
      acc = tx_ready_a[0];
      tick();
      budget++;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          tx_data_a[7:0] = bytes0[idx];
          tx_last_a[0]   = (idx == 2);
        end else begin
          tx_valid_a[0] = 1'b0;
          tx_last_a[0]  = 1'b0;
        end
      end
      @(negedge clk);
    end
    while (!tx_ready_a[1] && budget < 40) begin
      tick(); @(negedge clk); budget++;
    end
    vectors++;
    if (budget >= 40) begin
      miscompares++; $display("FAIL t1_timeout: got %0d cycles want <40", budget);
    end
    tick();
    tx_valid_a = 2'b00; tx_last_a = 2'b00;
    tick(); tick();
    vectors++;
    if (log_a.size() !== base + 4) begin
      miscompares++; $display("FAIL t1_count: got %0d want %0d", log_a.size() - base, 4);
    end
    for (int i = 0; i < 4; i++) begin
      got = (log_a.size() > base + i) ? log_a[base + i] : 8'hxx;
      vectors++;
      if (got !== expv[i]) begin
        miscompares++; $display("FAIL t1_byte%0d: got %02h want %02h", i, got, expv[i]);
      end
    end
  endtask

  // Three requesters with single-byte packets: grants rotate 0,1,2,0,1,2.
  task automatic test_round_robin();
    logic [7:0] expv [6] = '{8'h10, 8'h11, 8'h12, 8'h10, 8'h11, 8'h12};
    logic [7:0] got;
    int n, budget, base;
    base = log_b.size();
    tx_data_b = {8'h12, 8'h11, 8'h10}; tx_last_b = 3'b111; tx_valid_b = 3'b111;
    n = 0; budget = 0;
    while (n < 6 && budget < 60) begin
      @(negedge clk);
      if (|tx_ready_b) n++;
      tick();
      budget++;
    end
    tx_valid_b = '0; tx_last_b = '0;
    vectors++;
    if (n != 6) begin
      miscompares++; $display("FAIL t2_timeout: got %0d grants want 6", n);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      got = (log_b.size() > base + i) ? log_b[base + i] : 8'hxx;
      vectors++;
      if (got !== expv[i]) begin
        miscompares++; $display("FAIL t2_grant%0d: got byte %02h want %02h", i, got, expv[i]);
      end
    end
  endtask

  // Long uart_dat_wait: we held high, ready low, byte accepted exactly once.
  task automatic test_wait_stall();
    int base;
    base = log_a.size();
    wait_a = 1'b1;
    tx_data_a[7:0] = 8'h7E; tx_last_a = 2'b01; tx_valid_a = 2'b01;
    @(negedge clk);
    tick();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if ({we_a, tx_ready_a[0], di_a} !== {1'b1, 1'b0, 32'h7E}) begin
        miscompares++; $display("FAIL t3_stall_c%0d: got we=%b rdy=%b di=%h want we=1 rdy=0 di=7e", c, we_a, tx_ready_a[0], di_a);
      end
      tick();
    end
    wait_a = 1'b0;
    @(negedge clk);
    vectors++;
    if ({we_a, tx_ready_a} !== 3'b101) begin
      miscompares++; $display("FAIL t3_release: got %b want 101", {we_a, tx_ready_a});
    end
    tick();
    tx_valid_a = 2'b00; tx_last_a = 2'b00;
    tick(); tick();
    vectors++;
    if (log_a.size() !== base + 1) begin
      miscompares++; $display("FAIL t3_once: got %0d writes want 1", log_a.size() - base);
    end
    vectors++;
    if (log_a.size() > base && log_a[base] !== 8'h7E) begin
      miscompares++; $display("FAIL t3_byte: got %02h want 7e", log_a[base]);
    end
  endtask

  // LOCK_TIMEOUT=8: idle owner 0 loses the lock after 8 idle cycles, req1 then granted.
  task automatic test_lock_timeout();
    tx_data_b[7:0] = 8'h60; tx_last_b = 3'b000; tx_valid_b = 3'b001;
    @(negedge clk);
    tick();
    @(negedge clk);
    vectors++;
    if ({owner_valid_b, owner_b, tx_ready_b} !== 6'b100001) begin
      miscompares++; $display("FAIL t4_grant0: got %b want 100001", {owner_valid_b, owner_b, tx_ready_b});
    end
    tick();
    tx_valid_b = 3'b010; tx_last_b = 3'b010; tx_data_b[15:8] = 8'h61;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vectors++;
      if ({owner_valid_b, owner_b, tx_ready_b[1]} !== 4'b1000) begin
        miscompares++; $display("FAIL t4_held_k%0d: got %b want 1000", k, {owner_valid_b, owner_b, tx_ready_b[1]});
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (owner_valid_b !== 1'b0) begin
      miscompares++; $display("FAIL t4_release: got owner_valid=%b want 0", owner_valid_b);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({owner_valid_b, owner_b, tx_ready_b} !== 6'b101010) begin
      miscompares++; $display("FAIL t4_grant1: got %b want 101010", {owner_valid_b, owner_b, tx_ready_b});
    end
    tick();
    tx_valid_b = '0; tx_last_b = '0;
    tick();
  endtask

  // RX routing to owner 1, hold until pop, second byte waits, wrong-requester ready ignored.
  task automatic test_rx_route();
    tx_data_a[15:8] = 8'h31; tx_last_a = 2'b10; tx_valid_a = 2'b10;
    @(negedge clk);
    tick();
    @(negedge clk);
    vectors++;
    if ({owner_a, tx_ready_a} !== 3'b110) begin
      miscompares++; $display("FAIL t5_owner1: got %b want 110", {owner_a, tx_ready_a});
    end
    tick();
    tx_valid_a = 2'b00; tx_last_a = 2'b00;
    do_a = 32'h1A5;
    @(negedge clk);
    vectors++;
    if ({re_a, rx_valid_a} !== 3'b100) begin
      miscompares++; $display("FAIL t5_re_pulse: got %b want 100", {re_a, rx_valid_a});
    end
    tick();
    do_a = 32'h0;
    @(negedge clk);
    vectors++;
    if ({re_a, rx_valid_a, rx_data_a} !== {1'b0, 2'b10, 8'hA5}) begin
      miscompares++; $display("FAIL t5_held: got re=%b v=%b d=%02h want re=0 v=10 d=a5", re_a, rx_valid_a, rx_data_a);
    end
    tick();
    do_a = 32'h15A; rx_ready_a = 2'b01;
    @(negedge clk);
    vectors++;
    if ({re_a, rx_valid_a} !== 3'b010) begin
      miscompares++; $display("FAIL t5_blocked: got %b want 010", {re_a, rx_valid_a});
    end
    tick();
    rx_ready_a = 2'b00;
    @(negedge clk);
    vectors++;
    if ({re_a, rx_valid_a, rx_data_a} !== {1'b0, 2'b10, 8'hA5}) begin
      miscompares++; $display("FAIL t5_wrong_ready: got re=%b v=%b d=%02h want re=0 v=10 d=a5", re_a, rx_valid_a, rx_data_a);
    end
    tick();
    rx_ready_a = 2'b10;
    @(negedge clk);
    vectors++;
    if ({re_a, rx_valid_a} !== 3'b010) begin
      miscompares++; $display("FAIL t5_pop_bubble: got %b want 010", {re_a, rx_valid_a});
    end
    tick();
    rx_ready_a = 2'b00;
    @(negedge clk);
    vectors++;
    if ({re_a, rx_valid_a} !== 3'b100) begin
      miscompares++; $display("FAIL t5_after_pop: got %b want 100", {re_a, rx_valid_a});
    end
    tick();
    do_a = 32'h0;
    @(negedge clk);
    vectors++;
    if ({re_a, rx_valid_a, rx_data_a} !== {1'b0, 2'b10, 8'h5A}) begin
      miscompares++; $display("FAIL t5_second: got re=%b v=%b d=%02h want re=0 v=10 d=5a", re_a, rx_valid_a, rx_data_a);
    end
    tick();
    rx_ready_a = 2'b10;
    tick();
    rx_ready_a = 2'b00;
    @(negedge clk);
    vectors++;
    if (rx_valid_a !== 2'b00) begin
      miscompares++; $display("FAIL t5_drained: got %b want 00", rx_valid_a);
    end
    tick();
  endtask

  // LOCK_TIMEOUT=0: idle owner keeps the lock; req1 never sees ready.
  task automatic test_no_timeout();
    tx_data_a[7:0] = 8'h66; tx_last_a = 2'b00; tx_valid_a = 2'b01;
    @(negedge clk);
    tick();
    @(negedge clk);
    vectors++;
    if ({owner_valid_a, owner_a, tx_ready_a} !== 4'b1001) begin
      miscompares++; $display("FAIL t4n_grant0: got %b want 1001", {owner_valid_a, owner_a, tx_ready_a});
    end
    tick();
    tx_valid_a = 2'b10; tx_last_a = 2'b10; tx_data_a[15:8] = 8'h77;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      vectors++;
      if ({owner_valid_a, owner_a, tx_ready_a[1]} !== 3'b100) begin
        miscompares++; $display("FAIL t4n_held_c%0d: got %b want 100", c, {owner_valid_a, owner_a, tx_ready_a[1]});
      end
      tick();
    end
  endtask

  // Async reset while locked with a full holding register; first grant afterwards goes to req0.
  task automatic test_reset_midpacket();
    tx_data_a[7:0] = 8'h88; tx_valid_a = 2'b11; tx_last_a = 2'b11; wait_a = 1'b1; do_a = 32'h1C3;
    @(negedge clk);
    vectors++;
    if ({owner_valid_a, we_a, re_a} !== 3'b111) begin
      miscompares++; $display("FAIL t6_pre: got %b want 111", {owner_valid_a, we_a, re_a});
    end
    tick();
    do_a = 32'h0;
    @(negedge clk);
    vectors++;
    if ({rx_valid_a, rx_data_a} !== {2'b01, 8'hC3}) begin
      miscompares++; $display("FAIL t6_hold: got v=%b d=%02h want v=01 d=c3", rx_valid_a, rx_data_a);
    end
    tick();
    resetn = 1'b0;
    #1;
    vectors++;
    if ({tx_ready_a, rx_valid_a, rx_data_a, owner_a, owner_valid_a, we_a, di_a, re_a} !== '0) begin
      miscompares++;
      $display("FAIL t6_async: got %h want 0", {tx_ready_a, rx_valid_a, rx_data_a, owner_a, owner_valid_a, we_a, di_a, re_a});
    end
    tick(); tick();
    resetn = 1'b1; wait_a = 1'b0;
    @(negedge clk);
    vectors++;
    if (owner_valid_a !== 1'b0) begin
      miscompares++; $display("FAIL t6_idle: got owner_valid=%b want 0", owner_valid_a);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({owner_valid_a, owner_a, tx_ready_a} !== 4'b1001) begin
      miscompares++; $display("FAIL t6_first_grant: got %b want 1001", {owner_valid_a, owner_a, tx_ready_a});
    end
    tick();
    tx_valid_a = 2'b00; tx_last_a = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_packet_lock();
    test_round_robin();
    test_wait_stall();
    test_lock_timeout();
    test_rx_route();
    test_no_timeout();
    test_reset_midpacket();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
